// File: rtl/trivium_word_packer.sv
// Packs the 1-bit trivium keystream LSB-first into WIDTH-bit words and queues them in a
// first-word-fall-through FIFO. Optional repetition alarm is enabled by REPEAT_CHECK_EN.
`timescale 1ns/1ps
module trivium_word_packer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DISCARD   = 0,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned REP_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  input  logic             ks_bit_i,
  input  logic             ks_valid_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             alarm_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

`ifdef REPEAT_CHECK_EN
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);
  typedef enum logic [1:0] {StDiscard, StCollect, StAlarm} state_e;
`else
  typedef enum logic [0:0] {StDiscard, StCollect} state_e;
`endif

  // With no bits to discard the packer starts straight in collection.
  localparam state_e StStart = (DISCARD == 0) ? StCollect : StDiscard;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    disc_cnt_q, disc_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             alarm_q, alarm_d;
`ifdef REPEAT_CHECK_EN
  logic [RW-1:0]    run_q, run_d, run_next;
  logic             last_q, last_d;
`endif

  logic             push, pop, full, wr_en, drop;
  logic [WIDTH-1:0] push_word;

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign alarm_o     = alarm_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    disc_cnt_d = disc_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    alarm_d    = alarm_q;
    push       = 1'b0;
    push_word  = '0;
`ifdef REPEAT_CHECK_EN
    run_d      = run_q;
    last_d     = last_q;
    run_next   = '0;
`endif

    if (ks_valid_i) begin
      if (state_q == StDiscard) begin
        if (32'(disc_cnt_q) == DISCARD - 1) begin
          state_d    = StCollect;
          disc_cnt_d = '0;
        end else begin
          disc_cnt_d = disc_cnt_q + 1'b1;
        end
      end else if (state_q == StCollect) begin
        sr_d[bit_cnt_q] = ks_bit_i;
        if (32'(bit_cnt_q) == WIDTH - 1) begin
          push      = 1'b1;
          push_word = sr_d;
          sr_d      = '0;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
`ifdef REPEAT_CHECK_EN
        // run_q == 0 marks "no previous bit" since the last clear.
        run_next = (run_q != '0 && ks_bit_i == last_q) ? run_q + 1'b1 : RW'(1);
        run_d    = run_next;
        last_d   = ks_bit_i;
        if (32'(run_next) == REP_LIMIT) begin
          // The tripping bit's word is suppressed along with everything after it.
          push    = 1'b0;
          alarm_d = 1'b1;
          state_d = StAlarm;
        end
`endif
      end
    end

    pop   = out_valid_o && out_ready_i;
    full  = (count_q == (AW+1)'(DEPTH));
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_en) count_d = count_q - 1'b1;

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    if (restart_i) begin
      state_d    = StStart;
      sr_d       = '0;
      bit_cnt_d  = '0;
      disc_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
      alarm_d    = 1'b0;
      wr_en      = 1'b0;
`ifdef REPEAT_CHECK_EN
      run_d      = '0;
      last_d     = 1'b0;
`endif
    end
`ifndef REPEAT_CHECK_EN
    alarm_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StStart;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      disc_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      alarm_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
`ifdef REPEAT_CHECK_EN
      run_q      <= '0;
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      alarm_q    <= alarm_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_word;
`ifdef REPEAT_CHECK_EN
      run_q      <= run_d;
      last_q     <= last_d;
`endif
    end
  end

endmodule
